game_timer: RTL and testbench

- Match countdown timer for the Bomberman game.
- Consumes the 1 Hz square wave from the clock divider stage (clk_1s, 50% duty, generated from clk_50) and counts remaining match time down in BCD as M:SS.
- Provides run, hurry-up and time-up indications to the game FSM and the score/time display.
- Purely synchronous to clk_50; clk_1s is treated as a data input, never as a clock.

---
 rtl/game_timer.sv | 159 +++++++++++++++
 tb/tb_game_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// rtl/game_timer.sv - match countdown timer, BCD M:SS, driven by 1 Hz tick edges
//
// Counts remaining match time down once per rising edge of clk_1s (sampled as
// data in the clk_50 domain) and flags run / hurry-up / time-up to the game FSM.
//
// Ports:
//   clk_50     in   system clock
//   reset_n    in   asynchronous active-low reset
//   clk_1s     in   1 Hz square wave, synchronous to clk_50
//   start      in   level, begin or resume counting
//   pause      in   level, suspend counting
//   reload     in   level, return to IDLE with the start value
//   min        out  minutes digit, BCD
//   sec_tens   out  seconds tens digit, 0-5
//   sec_units  out  seconds units digit, BCD
//   running    out  high while counting
//   hurry      out  remaining time at or below HURRY_SEC while min is 0 (RUN/PAUSE)
//   time_up    out  single-cycle pulse when 0:00 is first shown
//   expired    out  high in DONE
module game_timer #(
    parameter int unsigned START_MIN = 3,
    parameter int unsigned START_SEC = 0,
    parameter int unsigned HURRY_SEC = 30
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       clk_1s,
    input  logic       start,
    input  logic       pause,
    input  logic       reload,
    output logic [3:0] min,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       hurry,
    output logic       time_up,
    output logic       expired
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] START_MIN_D   = 4'(START_MIN);
    localparam logic [2:0] START_TENS_D  = 3'(START_SEC / 10);
    localparam logic [3:0] START_UNITS_D = 4'(START_SEC % 10);
    localparam logic [6:0] HURRY_SEC_D   = 7'(HURRY_SEC);

    logic [1:0] state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [2:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       clk_1s_q, clk_1s_d;
    logic       time_up_q, time_up_d;

    logic       tick;
    logic       is_zero;
    logic       is_one;
    logic [6:0] sec_val;

    assign tick    = clk_1s & ~clk_1s_q;
    assign is_zero = (min_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd0);
    assign is_one  = (min_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd1);

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        tens_d    = tens_q;
        units_d   = units_q;
        clk_1s_d  = clk_1s;
        time_up_d = 1'b0;

        if (reload) begin
            // Reload beats everything, including a tick arriving this cycle.
            state_d = ST_IDLE;
            min_d   = START_MIN_D;
            tens_d  = START_TENS_D;
            units_d = START_UNITS_D;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // A 0:00 start value has nothing to count; expire at once.
                        if (is_zero) begin
                            state_d   = ST_DONE;
                            time_up_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (units_q != 4'd0) begin
                            units_d = units_q - 4'd1;
                        end else begin
                            units_d = 4'd9;
                            if (tens_q != 3'd0) begin
                                tens_d = tens_q - 3'd1;
                            end else begin
                                tens_d = 3'd5;
                                if (min_q != 4'd0) begin
                                    min_d = min_q - 4'd1;
                                end
                            end
                        end
                    end
                    // Reaching 0:00 wins over a coincident pause.
                    if (tick && is_one) begin
                        state_d   = ST_DONE;
                        time_up_d = 1'b1;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            min_q     <= START_MIN_D;
            tens_q    <= START_TENS_D;
            units_q   <= START_UNITS_D;
            // Start high so a clk_1s already high at reset release is not a tick.
            clk_1s_q  <= 1'b1;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            clk_1s_q  <= clk_1s_d;
            time_up_q <= time_up_d;
        end
    end

    assign sec_val   = (7'(tens_q) * 7'd10) + 7'(units_q);

    assign min       = min_q;
    assign sec_tens  = tens_q;
    assign sec_units = units_q;
    assign running   = (state_q == ST_RUN);
    assign expired   = (state_q == ST_DONE);
    assign time_up   = time_up_q;
    assign hurry     = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) &&
                       (min_q == 4'd0) && (sec_val <= HURRY_SEC_D);

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - self-checking bench for game_timer
module tb_game_timer;

    logic clk_50  = 1'b0;
    logic reset_n = 1'b0;
    logic clk_1s  = 1'b0;
    logic start   = 1'b0;
    logic pause   = 1'b0;
    logic reload  = 1'b0;

    always #10 clk_50 = ~clk_50;

    // One output bundle per parameterisation: {min, tens, units, running, hurry, time_up, expired}
    logic [3:0] d_min, s_min, z_min, t_min;
    logic [2:0] d_tens, s_tens, z_tens, t_tens;
    logic [3:0] d_units, s_units, z_units, t_units;
    logic d_run, s_run, z_run, t_run;
    logic d_hur, s_hur, z_hur, t_hur;
    logic d_tu, s_tu, z_tu, t_tu;
    logic d_exp, s_exp, z_exp, t_exp;

    game_timer #(.START_MIN(3), .START_SEC(0), .HURRY_SEC(30)) u_def (
        .clk_50(clk_50), .reset_n(reset_n), .clk_1s(clk_1s), .start(start), .pause(pause),
        .reload(reload), .min(d_min), .sec_tens(d_tens), .sec_units(d_units), .running(d_run),
        .hurry(d_hur), .time_up(d_tu), .expired(d_exp));

    game_timer #(.START_MIN(0), .START_SEC(3), .HURRY_SEC(30)) u_s3 (
        .clk_50(clk_50), .reset_n(reset_n), .clk_1s(clk_1s), .start(start), .pause(pause),
        .reload(reload), .min(s_min), .sec_tens(s_tens), .sec_units(s_units), .running(s_run),
        .hurry(s_hur), .time_up(s_tu), .expired(s_exp));

    game_timer #(.START_MIN(0), .START_SEC(0), .HURRY_SEC(30)) u_zero (
        .clk_50(clk_50), .reset_n(reset_n), .clk_1s(clk_1s), .start(start), .pause(pause),
        .reload(reload), .min(z_min), .sec_tens(z_tens), .sec_units(z_units), .running(z_run),
        .hurry(z_hur), .time_up(z_tu), .expired(z_exp));

    game_timer #(.START_MIN(2), .START_SEC(0), .HURRY_SEC(30)) u_two (
        .clk_50(clk_50), .reset_n(reset_n), .clk_1s(clk_1s), .start(start), .pause(pause),
        .reload(reload), .min(t_min), .sec_tens(t_tens), .sec_units(t_units), .running(t_run),
        .hurry(t_hur), .time_up(t_tu), .expired(t_exp));

    wire [14:0] d_out = {d_min, d_tens, d_units, d_run, d_hur, d_tu, d_exp};
    wire [14:0] s_out = {s_min, s_tens, s_units, s_run, s_hur, s_tu, s_exp};
    wire [14:0] z_out = {z_min, z_tens, z_units, z_run, z_hur, z_tu, z_exp};
    wire [14:0] t_out = {t_min, t_tens, t_units, t_run, t_hur, t_tu, t_exp};

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [14:0] exp_out(input int m, input int t, input int u,
                                            input bit r, input bit h, input bit tu, input bit ex);
        exp_out = {4'(m), 3'(t), 4'(u), r, h, tu, ex};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got m%0d:%0d%0d r%0b h%0b tu%0b ex%0b, want m%0d:%0d%0d r%0b h%0b tu%0b ex%0b",
                      name, act[14:11], act[10:8], act[7:4], act[3], act[2], act[1], act[0],
                      exp[14:11], exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk_50);
        #1;
    endtask

    task automatic tick();
        clk_1s = 1'b1;
        cyc();
        clk_1s = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        start = 1'b0; pause = 1'b0; reload = 1'b0; clk_1s = 1'b0;
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic begin_run();
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    typedef struct {
        logic st, pa, rl, c1;
        int   m, t, u;
        bit   r, h, tu, ex;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // Each record is one clk_50 cycle on the 0:03 instance; outputs checked after that edge.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1'b1, 1'b1, 1'b0, 1'b0}; // start
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2, 1'b1, 1'b1, 1'b0, 1'b0}; // tick
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0}; // tick
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0}; // level held: no tick
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1}; // 0:00, time_up
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1}; // tick in DONE ignored
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0}; // reload
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 3, 1'b1, 1'b1, 1'b0, 1'b0}; // IDLE: start wins
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0}; // RUN: pause + tick
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1'b1, 1'b1, 1'b0, 1'b0}; // PAUSE: start wins
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0}; // RUN: pause wins
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0}; // reload

        // Reset values
        do_reset();
        chk("reset_def", d_out, exp_out(3, 0, 0, 0, 0, 0, 0));
        chk("reset_s3", s_out, exp_out(0, 0, 3, 0, 0, 0, 0));

        // Countdown to 0:00 and control-precedence table
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].st; pause = vecs[i].pa; reload = vecs[i].rl; clk_1s = vecs[i].c1;
            cyc();
            chk($sformatf("vec%0d", i), s_out,
                exp_out(vecs[i].m, vecs[i].t, vecs[i].u, vecs[i].r, vecs[i].h, vecs[i].tu, vecs[i].ex));
        end
        start = 1'b0; pause = 1'b0; reload = 1'b0; clk_1s = 1'b0;

        // Borrow chain from 2:00
        begin_run();
        tick();
        chk("borrow_1_59", t_out, exp_out(1, 5, 9, 1, 0, 0, 0));
        for (int i = 0; i < 59; i++) tick();
        chk("at_1_00", t_out, exp_out(1, 0, 0, 1, 0, 0, 0));
        tick();
        chk("borrow_0_59", t_out, exp_out(0, 5, 9, 1, 0, 0, 0));
        for (int i = 0; i < 28; i++) tick();
        chk("at_0_31", t_out, exp_out(0, 3, 1, 1, 0, 0, 0));
        tick();
        chk("hurry_0_30", t_out, exp_out(0, 3, 0, 1, 1, 0, 0));

        // Pause with coincident tick at 1:45
        begin_run();
        for (int i = 0; i < 75; i++) tick();
        chk("at_1_45", d_out, exp_out(1, 4, 5, 1, 0, 0, 0));
        pause = 1'b1; clk_1s = 1'b1;
        cyc();
        chk("pause_tick", d_out, exp_out(1, 4, 4, 0, 0, 0, 0));
        clk_1s = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) tick();
        chk("paused_hold", d_out, exp_out(1, 4, 4, 0, 0, 0, 0));
        pause = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume", d_out, exp_out(1, 4, 4, 1, 0, 0, 0));
        tick();
        chk("resume_tick", d_out, exp_out(1, 4, 3, 1, 0, 0, 0));

        // Reload with coincident tick at 0:10
        begin_run();
        for (int i = 0; i < 170; i++) tick();
        chk("at_0_10", d_out, exp_out(0, 1, 0, 1, 1, 0, 0));
        reload = 1'b1; clk_1s = 1'b1;
        cyc();
        chk("reload_tick", d_out, exp_out(3, 0, 0, 0, 0, 0, 0));
        reload = 1'b0; clk_1s = 1'b0;
        cyc();
        chk("reload_after", d_out, exp_out(3, 0, 0, 0, 0, 0, 0));

        // Reset released with clk_1s high, then asynchronous reset mid-count
        clk_1s = 1'b1; reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        chk("no_spurious_tick", d_out, exp_out(3, 0, 0, 1, 0, 0, 0));
        clk_1s = 1'b0;
        cyc();
        tick();
        chk("first_true_tick", d_out, exp_out(2, 5, 9, 1, 0, 0, 0));
        tick();
        #4 reset_n = 1'b0;
        #1 chk("async_reset", d_out, exp_out(3, 0, 0, 0, 0, 0, 0));
        cyc();
        reset_n = 1'b1;
        cyc();
        tick();
        chk("no_resume", d_out, exp_out(3, 0, 0, 0, 0, 0, 0));

        // Zero start value
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("zero_start", z_out, exp_out(0, 0, 0, 0, 0, 1, 1));
        cyc();
        chk("zero_pulse_end", z_out, exp_out(0, 0, 0, 0, 0, 0, 1));
        tick(); tick();
        chk("zero_ticks", z_out, exp_out(0, 0, 0, 0, 0, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
